// File: rtl/rc6_key_schedule.sv
// RC6 key expansion engine: builds the T-word round-key table S from the user key.
// The finished table is read through a registered port while ready is high.
module rc6_key_schedule #(
    parameter int W         = 32,
    parameter int R         = 20,
    parameter int KEY_BYTES = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [8*KEY_BYTES-1:0]      key,
    output logic                        busy,
    output logic                        done,
    output logic                        ready,
    input  logic [$clog2(2*R+4)-1:0]    rd_addr,
    output logic [W-1:0]                rd_data
);

    // state  | meaning
    // IDLE   | waiting for start; table valid when ready=1
    // LOAD   | key words latched, prime S generator
    // INIT   | S[i] = P + i*Q, one word per cycle
    // MIX    | first cycle clears A/B/i/j, then N mixing iterations
    // DONE   | one-cycle done pulse, table marked ready

    localparam int T  = 2 * R + 4;
    localparam int C  = KEY_BYTES / 4;
    localparam int N  = 3 * ((C > T) ? C : T);
    localparam int AW = $clog2(T);
    localparam int JW = (C > 1) ? $clog2(C) : 1;
    localparam int CW = $clog2(N + 1);
    localparam int SW = $clog2(W);
    localparam logic [W-1:0] P = 32'hB7E15163;
    localparam logic [W-1:0] Q = 32'h9E3779B9;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_INIT, S_MIX, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    s_q [T];
    logic [W-1:0]    s_d [T];
    logic [W-1:0]    l_q [C];
    logic [W-1:0]    l_d [C];
    logic [W-1:0]    a_q, a_d, b_q, b_d, init_q, init_d;
    logic [AW-1:0]   i_q, i_d;
    logic [JW-1:0]   j_q, j_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ready_q, ready_d;
    logic [W-1:0]    rd_data_q, rd_data_d;
    logic [W-1:0]    a_new, ab_sum, b_new;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [SW-1:0] n);
        logic [2*W-1:0] t;
        t = {x, x} << n;
        return t[2*W-1:W];
    endfunction

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        l_d       = l_q;
        a_d       = a_q;
        b_d       = b_q;
        init_d    = init_q;
        i_d       = i_q;
        j_d       = j_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        a_new     = rotl(s_q[i_q] + a_q + b_q, SW'(3));
        ab_sum    = a_new + b_q;
        b_new     = rotl(l_q[j_q] + ab_sum, ab_sum[SW-1:0]);
        rd_data_d = ({1'b0, rd_addr} < (AW + 1)'(T)) ? s_q[rd_addr] : '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // byte k sits at key[8k+7:8k], so each 32-bit slice is already L[j] little-endian
                    for (int k = 0; k < C; k++) l_d[k] = key[32*k +: 32];
                    ready_d = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                i_d     = '0;
                init_d  = P;
                state_d = S_INIT;
            end
            S_INIT: begin
                s_d[i_q] = init_q;
                init_d   = init_q + Q;
                i_d      = i_q + 1'b1;
                if (i_q == AW'(T - 1)) begin
                    cnt_d   = CW'(N);
                    state_d = S_MIX;
                end
            end
            S_MIX: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(N)) begin
                    a_d = '0;
                    b_d = '0;
                    i_d = '0;
                    j_d = '0;
                end else begin
                    s_d[i_q] = a_new;
                    l_d[j_q] = b_new;
                    a_d      = a_new;
                    b_d      = b_new;
                    i_d      = (i_q == AW'(T - 1)) ? '0 : i_q + 1'b1;
                    j_d      = (j_q == JW'(C - 1)) ? '0 : j_q + 1'b1;
                    if (cnt_q == '0) state_d = S_DONE;
                end
            end
            S_DONE: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b0;
            rd_data_q <= '0;
            i_q       <= '0;
            j_q       <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            rd_data_q <= rd_data_d;
            i_q       <= i_d;
            j_q       <= j_d;
            cnt_q     <= cnt_d;
        end
    end

    // table and working registers carry no reset; ready=0 marks them stale
    always_ff @(posedge clk) begin
        s_q    <= s_d;
        l_q    <= l_d;
        a_q    <= a_d;
        b_q    <= b_d;
        init_q <= init_d;
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign ready   = ready_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_rc6_key_schedule.sv
// Directed bench for rc6_key_schedule: latency, reset, read port and RC6 known-answer vectors.
module tb_rc6_key_schedule;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [127:0] key;
    logic         busy, done, ready;
    logic [5:0]   rd_addr;
    logic [31:0]  rd_data;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_s [44];
    logic [31:0] got_s [44];

    localparam logic [127:0] KEY2 = 128'h78675645_34231201_efcdab89_67452301;

    always #5 clk = ~clk;

    rc6_key_schedule #(.W(32), .R(20), .KEY_BYTES(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .key     (key),
        .busy    (busy),
        .done    (done),
        .ready   (ready),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [31:0] n);
        logic [63:0] t;
        t = {x, x} << n[4:0];
        return t[63:32];
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input logic [31:0] n);
        logic [63:0] t;
        t = {x, x} >> n[4:0];
        return t[31:0];
    endfunction

    task automatic build_model(input logic [127:0] k);
        logic [31:0] l [4];
        logic [31:0] a, b;
        int i, j;
        for (int m = 0; m < 4; m++) l[m] = k[32*m +: 32];
        exp_s[0] = 32'hB7E15163;
        for (int m = 1; m < 44; m++) exp_s[m] = exp_s[m-1] + 32'h9E3779B9;
        a = 0; b = 0; i = 0; j = 0;
        for (int m = 0; m < 132; m++) begin
            a = rotl(exp_s[i] + a + b, 3);
            exp_s[i] = a;
            b = rotl(l[j] + a + b, a + b);
            l[j] = b;
            i = (i + 1) % 44;
            j = (j + 1) % 4;
        end
    endtask

    task automatic read_check(input string nm);
        for (int ad = 0; ad < 64; ad++) begin
            rd_addr = 6'(ad);
            @(posedge clk); #1;
            if (ad < 44) begin
                got_s[ad] = rd_data;
                chk($sformatf("%s_s%0d", nm, ad), rd_data, exp_s[ad]);
            end else begin
                chk($sformatf("%s_oob%0d", nm, ad), rd_data, 32'h0);
            end
        end
        rd_addr = 6'd0;
    endtask

    task automatic rc6_enc(input logic [31:0] pa, pb, pc, pd,
                           output logic [31:0] ca, cb, cc, cd);
        logic [31:0] a, b, c, d, t, u, x;
        a = pa; b = pb + got_s[0]; c = pc; d = pd + got_s[1];
        for (int r = 1; r <= 20; r++) begin
            t = rotl(b * ((b << 1) + 32'd1), 5);
            u = rotl(d * ((d << 1) + 32'd1), 5);
            a = rotl(a ^ t, u) + got_s[2*r];
            c = rotl(c ^ u, t) + got_s[2*r+1];
            x = a; a = b; b = c; c = d; d = x;
        end
        ca = a + got_s[42]; cb = b; cc = c + got_s[43]; cd = d;
    endtask

    task automatic rc6_dec(input logic [31:0] ca, cb, cc, cd,
                           output logic [31:0] pa, pb, pc, pd);
        logic [31:0] a, b, c, d, t, u, x;
        a = ca - got_s[42]; b = cb; c = cc - got_s[43]; d = cd;
        for (int r = 20; r >= 1; r--) begin
            x = d; d = c; c = b; b = a; a = x;
            u = rotl(d * ((d << 1) + 32'd1), 5);
            t = rotl(b * ((b << 1) + 32'd1), 5);
            c = rotr(c - got_s[2*r+1], t) ^ u;
            a = rotr(a - got_s[2*r], u) ^ t;
        end
        pa = a; pb = b - got_s[0]; pc = c; pd = d - got_s[1];
    endtask

    // restart_at / rst_at: edge index (after the start edge) before which start or rst is raised; 0 = never
    task automatic expand(input logic [127:0] k, input int restart_at, input int rst_at, input bit scramble);
        int n;
        bit seen, was_rst;
        n = 0; seen = 0; was_rst = 0;
        key   = k;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ready_clr_on_start", 32'(ready), 32'h0);
        chk("busy_after_start", 32'(busy), 32'h1);
        while (!seen && !was_rst && n < 400) begin
            if (scramble) key = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (n + 1 == restart_at) start = 1'b1;
            if (n + 1 == rst_at) rst = 1'b1;
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            if (rst) was_rst = 1;
            else if (done) seen = 1;
        end
        if (was_rst) begin
            rst = 1'b0;
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_ready", 32'(ready), 32'h0);
            chk("rst_done", 32'(done), 32'h0);
            chk("rst_rd_data", rd_data, 32'h0);
        end else begin
            chk("done_latency", 32'(n), 32'd178);
            @(posedge clk); #1;
            chk("ready_after_done", 32'(ready), 32'h1);
            chk("busy_after_done", 32'(busy), 32'h0);
            chk("done_one_cycle", 32'(done), 32'h0);
        end
    endtask

    initial begin
        logic [31:0] r0, r1, r2, r3;
        rst = 1'b1; start = 1'b0; key = '0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_ready", 32'(ready), 32'h0);
        chk("reset_rd_data", rd_data, 32'h0);
        rst = 1'b0;

        // all-zero key, zero-plaintext known answer
        expand(128'h0, 0, 0, 1'b0);
        build_model(128'h0);
        read_check("zk");
        rc6_enc(32'h0, 32'h0, 32'h0, 32'h0, r0, r1, r2, r3);
        chk("zk_ct0", r0, 32'h36a5c38f);
        chk("zk_ct1", r1, 32'h78f7b156);
        chk("zk_ct2", r2, 32'h4edf29c1);
        chk("zk_ct3", r3, 32'h1ea44898);

        // second key with a stray start mid-run and key bits churning while busy
        expand(KEY2, 50, 0, 1'b1);
        build_model(KEY2);
        read_check("k2");
        rc6_enc(32'h35241302, 32'h79685746, 32'hbdac9b8a, 32'hf1e0dfce, r0, r1, r2, r3);
        chk("k2_ct0", r0, 32'h2f194e52);
        chk("k2_ct1", r1, 32'h23c61547);
        chk("k2_ct2", r2, 32'h36f6511f);
        chk("k2_ct3", r3, 32'h183fa47e);
        rc6_dec(32'h2f194e52, 32'h23c61547, 32'h36f6511f, 32'h183fa47e, r0, r1, r2, r3);
        chk("k2_pt0", r0, 32'h35241302);
        chk("k2_pt1", r1, 32'h79685746);
        chk("k2_pt2", r2, 32'hbdac9b8a);
        chk("k2_pt3", r3, 32'hf1e0dfce);

        // reset in the middle of MIX, then a clean expansion
        expand(128'h0, 0, 100, 1'b0);
        expand(KEY2, 0, 0, 1'b0);
        read_check("k2r");
        rc6_enc(32'h35241302, 32'h79685746, 32'hbdac9b8a, 32'hf1e0dfce, r0, r1, r2, r3);
        chk("k2r_ct0", r0, 32'h2f194e52);
        chk("k2r_ct3", r3, 32'h183fa47e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
